// File: rtl/aes_round_sched.sv
// Round scheduler for an iterative AES-128 encryptor: sequences a shared external
// round datapath and key-expansion step through INIT, ten rounds and a hold state.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for in_valid; in_ready high
// S_INIT  | initial AddRoundKey, first key-expansion step
// S_ROUND | rounds 1..NROUNDS; last one skips MixColumns
// S_DONE  | ciphertext held on out_data until out_ready
module aes_round_sched #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic [1:0]   dp_mode,
  input  logic [127:0] dp_result,
  output logic [7:0]   kx_rcon,
  input  logic [127:0] kx_next,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   round,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ARK   = 2'b00;
  localparam logic [1:0] MODE_FULL  = 2'b01;
  localparam logic [1:0] MODE_FINAL = 2'b10;
  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  state_t       state, state_nxt;
  logic [127:0] st_reg, st_nxt;
  logic [127:0] key_reg, key_nxt;
  logic [7:0]   rcon, rcon_nxt;
  logic [3:0]   round_reg, round_nxt;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      st_reg    <= '0;
      key_reg   <= '0;
      rcon      <= 8'h01;
      round_reg <= '0;
    end else begin
      state     <= state_nxt;
      st_reg    <= st_nxt;
      key_reg   <= key_nxt;
      rcon      <= rcon_nxt;
      round_reg <= round_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    st_nxt    = st_reg;
    key_nxt   = key_reg;
    rcon_nxt  = rcon;
    round_nxt = round_reg;
    dp_mode   = MODE_ARK;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_nxt    = in_data;
          key_nxt   = in_key;
          rcon_nxt  = 8'h01;
          round_nxt = '0;
          state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        busy      = 1'b1;
        st_nxt    = dp_result;
        key_nxt   = kx_next;
        rcon_nxt  = xtime(rcon);
        round_nxt = 4'd1;
        state_nxt = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (round_reg < LAST_ROUND) begin
          dp_mode   = MODE_FULL;
          st_nxt    = dp_result;
          key_nxt   = kx_next;
          rcon_nxt  = xtime(rcon);
          round_nxt = round_reg + 4'd1;
        end else begin
          // final round: key, rcon and round counter freeze for DONE
          dp_mode   = MODE_FINAL;
          st_nxt    = dp_result;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dp_state = st_reg;
  assign dp_key   = key_reg;
  assign kx_rcon  = rcon;
  assign out_data = st_reg;
  assign round    = round_reg;

endmodule

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 The block SHALL have one parameter: NROUNDS, default 10, the AES-128 round count (fixed; other values are unsupported).
REQ-002 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-low.
REQ-004 in_valid  in  1  an input block is offered.
REQ-005 in_ready  out  1  the block can accept an input block.
REQ-006 in_data  in  128  plaintext block.
REQ-007 in_key  in  128  cipher key.
REQ-008 dp_state  out  128  state operand to the shared round datapath; SHALL always equal st_reg.
REQ-009 dp_key  out  128  round-key operand to the datapath; SHALL always equal key_reg.
REQ-010 dp_mode  out  2  datapath mode: 00 AddRoundKey only, 01 full round, 10 final round (no MixColumns), 11 unused.
REQ-011 dp_result  in  128  combinational datapath result for the current dp_state, dp_key and dp_mode.
REQ-012 kx_rcon  out  8  round constant for the key-expansion step.
REQ-013 kx_next  in  128  combinational next round key computed from dp_key and kx_rcon.
REQ-014 out_valid  out  1  a ciphertext block is available.
REQ-015 out_ready  in  1  the consumer accepts the ciphertext.
REQ-016 out_data  out  128  ciphertext; SHALL equal st_reg.
REQ-017 round  out  4  current round index.
REQ-018 busy  out  1  high in the INIT and ROUND states.

Function
REQ-019 The FSM SHALL have four states: IDLE, INIT, ROUND and DONE.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 out_valid SHALL be 1 only in DONE.
REQ-022 IDLE: on in_valid=1, st_reg<=in_data, key_reg<=in_key, rcon<=0x01, round<=0, and the FSM SHALL go to INIT; otherwise it SHALL hold.
REQ-023 INIT: dp_mode=00, st_reg<=dp_result, key_reg<=kx_next, rcon<=xtime(rcon), round<=1, next state ROUND.
REQ-024 ROUND with round<NROUNDS: dp_mode=01, st_reg<=dp_result, key_reg<=kx_next, rcon<=xtime(rcon), round<=round+1.
REQ-025 ROUND with round=NROUNDS: dp_mode=10, st_reg<=dp_result, and key_reg, rcon and round SHALL hold; next state DONE.
REQ-026 xtime(r) SHALL equal {r[6:0],0} XOR (r[7] ? 0x1B : 0x00), giving the sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-027 dp_mode SHALL be 00 in IDLE and DONE; in those states the datapath result SHALL be ignored.
REQ-028 DONE: st_reg, key_reg and round SHALL hold; on out_ready=1 the FSM SHALL go to IDLE.
REQ-029 Output and input handshakes SHALL NOT occur in the same cycle; the next block can be accepted no earlier than the cycle after the out handshake.
REQ-030 Latency: with acceptance at edge 0, out_valid SHALL first be high at cycle 12 (INIT in cycle 1, rounds 1..10 in cycles 2..11).
REQ-031 Throughput SHALL be one block per 13 cycles when out_ready is held at 1.
REQ-032 in_data and in_key SHALL be sampled only at acceptance; changes while busy SHALL have no effect.
REQ-033 round SHALL never exceed NROUNDS; the increment SHALL NOT wrap.

Reset
REQ-034 With rst=0 at a clock edge, the FSM SHALL go to IDLE and st_reg, key_reg and round SHALL go to 0, with rcon=0x01.
REQ-035 After that reset edge: in_ready=1, out_valid=0, busy=0, dp_mode=00, out_data=0, round=0, kx_rcon=0x01.
REQ-036 Reset asserted in any state, including mid-round or in DONE, SHALL abort the block with no output produced; the first accept SHALL be possible in the cycle after rst returns to 1.

Verification
REQ-037 FIPS-197 vector: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a with out_valid at cycle 12.
REQ-038 Sequence check: log dp_mode and kx_rcon per cycle -> 00/01, then 01 with rcon 02..36 for rounds 1..9, then 10 at round 10; round counts 0..10.
REQ-039 Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out_data stable, in_ready=0, in_valid ignored; release -> IDLE next cycle.
REQ-040 Back-to-back: two blocks with out_ready=1 and in_valid=1 always -> accepts 13 cycles apart, both ciphertexts correct.
REQ-041 Reset mid-operation at round 5 -> next cycle IDLE with out_valid=0 and round=0; a fresh FIPS-197 block then completes correctly.
REQ-042 Input corruption: change in_data and in_key every cycle while busy -> ciphertext matches the values sampled at acceptance.
